mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, giving the 128-bit chunk address width; the array holds 2^ADDR_BITS chunks.
REQ-002 SHALL have parameter DATA_BITS, default 128, giving the beat width; DATA_BITS/8 mask bits.
REQ-003 SHALL have parameter DATA_CYCLES, default 4, giving the beats per read refill; it SHALL be a power of two.
REQ-004 SHALL have parameter READ_LATENCY, default 4, giving the cycles from read accept to the first beat; minimum 1.
REQ-005 SHALL have parameter NACK_EVERY, default 3, giving the nack injection period (see Configuration).
REQ-006 SHALL have these ports, in this order (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, reset; synchronous, active-high; clock clk.
- mem_req_val, in, 1, command valid.
- mem_req_rdy, out, 1, command ready.
- mem_req_addr, in, ADDR_BITS, chunk address.
- mem_req_rw, in, 1, 1 = write, 0 = read.
- mem_req_data_valid, in, 1, write data valid.
- mem_req_data_ready, out, 1, write data ready.
- mem_req_data_bits, in, DATA_BITS, write data.
- mem_req_data_mask, in, DATA_BITS/8, byte enables.
- mem_req_data_offset, in, 2, chunk within the line for writes.
- mem_resp_val, out, 1, read beat valid.
- mem_resp_nack, out, 1, request rejected.
- mem_resp_data, out, DATA_BITS, read beat.

Function
REQ-007 SHALL implement the states IDLE, W_DATA, R_WAIT, R_BEAT and NACK.
REQ-008 SHALL drive mem_req_rdy high iff state is IDLE; a command is accepted on mem_req_val & mem_req_rdy at a clock edge.
REQ-009 On a read accept, SHALL latch base = {addr[ADDR_BITS-1:log2(DATA_CYCLES)], zeros} and go to R_WAIT.
REQ-010 On a write accept, SHALL latch addr and go to W_DATA.
REQ-011 In W_DATA, SHALL drive mem_req_data_ready high.
REQ-012 When mem_req_data_valid is also high in W_DATA, SHALL write chunk {addr[ADDR_BITS-1:2], offset}, updating only bytes whose mask bit is 1, then return to IDLE.
REQ-013 While mem_req_data_valid is low in W_DATA, SHALL stay in W_DATA indefinitely.
REQ-014 R_WAIT SHALL last READ_LATENCY-1 cycles, counted by a latency counter, then go to R_BEAT, or to NACK when nack is due.
REQ-015 R_BEAT SHALL assert mem_resp_val for exactly DATA_CYCLES consecutive cycles, with mem_resp_data = array[base+k] on beat k = 0..DATA_CYCLES-1, in order.
REQ-016 After the last beat, R_BEAT SHALL return to IDLE.
REQ-017 The first beat SHALL appear exactly READ_LATENCY cycles after the accepting edge.
REQ-018 NACK SHALL assert mem_resp_nack for exactly one cycle, with mem_resp_val low and no array access, then return to IDLE.
REQ-019 mem_resp_nack and mem_resp_val SHALL never be high in the same cycle.
REQ-020 The beat counter SHALL wrap at DATA_CYCLES; base+k SHALL never carry outside the aligned line.
REQ-021 mem_req_data_valid outside W_DATA SHALL be ignored, with no write.
REQ-022 Write data arriving in the same cycle as the write command SHALL NOT be captured; data is sampled only in W_DATA.
REQ-023 mem_req_data_ready, mem_resp_val and mem_resp_nack SHALL be registered or pure state decodes, with no combinational path from inputs.
REQ-024 The array SHALL be read-before-write-free: a write completes before the next command can be accepted.

Reset
REQ-025 reset SHALL force IDLE and clear the latency, beat and nack counters.
REQ-026 During reset, mem_req_rdy, mem_req_data_ready, mem_resp_val and mem_resp_nack SHALL be 0; mem_resp_data SHALL be 0.
REQ-027 Reset mid-read SHALL abort remaining beats; reset mid-write SHALL discard the pending write.
REQ-028 Array contents SHALL be unchanged by reset.

Configuration
REQ-029 Macro MEM_RESPONDER_NACK_EN, when defined, SHALL count accepted reads and nack every NACK_EVERY-th read: reads 3, 6, 9, ... with default 3.
REQ-030 A nacked read SHALL count toward the period; its retry is a new read.
REQ-031 Without MEM_RESPONDER_NACK_EN, mem_resp_nack SHALL be constant 0 and the nack counter SHALL be absent.

Structure
REQ-032 Package mem_responder_pkg SHALL hold the state enum and the default DATA_BITS, DATA_CYCLES and READ_LATENCY constants.
REQ-033 Sub-module mem_responder_array SHALL be a 1RW, byte-masked, 2^ADDR_BITS x DATA_BITS behavioural RAM.

Verification
REQ-034 Write addr=0x04, offset=1, mask=0x000F, data=0x...DDCCBBAA, then read addr=0x04 -> beat 1 low 32 bits = 0xDDCCBBAA, other bytes unchanged; 4 beats; first beat 4 cycles after accept.
REQ-035 Read addr=0x07 -> beats from chunks 0x04, 0x05, 0x06, 0x07, in order, contiguous, mem_req_rdy low throughout.
REQ-036 Write command accepted with data_valid low for 5 cycles, then high -> data_ready high in all 6 W_DATA cycles; write occurs only on the 6th; rdy returns the next cycle.
REQ-037 With MEM_RESPONDER_NACK_EN, NACK_EVERY=3, six reads -> reads 3 and 6 give a single-cycle nack and zero beats; the others give 4 beats.
REQ-038 Reset asserted after beat 1 of a read -> no further mem_resp_val; IDLE with rdy=1 in the first cycle after reset deasserts; array data intact on re-read.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared state encoding, default geometry and helpers
// for the mem_responder block.
package mem_responder_pkg;

    localparam int unsigned DEF_DATA_BITS    = 128;
    localparam int unsigned DEF_DATA_CYCLES  = 4;
    localparam int unsigned DEF_READ_LATENCY = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_W_DATA = 3'd1,
        ST_R_WAIT = 3'd2,
        ST_R_BEAT = 3'd3,
        ST_NACK   = 3'd4
    } state_e;

    // Counter width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_responder_array.sv
// mem_responder_array: 1RW byte-masked behavioural RAM, 2^ADDR_BITS x DATA_BITS.
// Ports: clk; we (write strobe); addr (chunk address); wmask (byte enables);
//        wdata (write data); rdata (asynchronous read of addr).
// Contents have no reset.
module mem_responder_array #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 128
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [ADDR_BITS-1:0]   addr,
    input  logic [DATA_BITS/8-1:0] wmask,
    input  logic [DATA_BITS-1:0]   wdata,
    output logic [DATA_BITS-1:0]   rdata
);
    localparam int unsigned DEPTH     = 1 << ADDR_BITS;
    localparam int unsigned MASK_BITS = DATA_BITS / 8;

    logic [DATA_BITS-1:0] mem [DEPTH];

    // Byte-masked write.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < MASK_BITS; i++) begin
                if (wmask[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: line-refill memory responder. Reads return DATA_CYCLES beats
// of an aligned line, the first beat sampled READ_LATENCY edges after accept;
// writes take one masked chunk in a separate data phase.
// Ports: clk, reset (sync, active-high); mem_req_* command/write-data channel;
//        mem_resp_val/mem_resp_nack/mem_resp_data response channel.
// Optional feature: define MEM_RESPONDER_NACK_EN to nack every NACK_EVERY-th read.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS    = 8,
    parameter int unsigned DATA_BITS    = DEF_DATA_BITS,
    parameter int unsigned DATA_CYCLES  = DEF_DATA_CYCLES,
    parameter int unsigned READ_LATENCY = DEF_READ_LATENCY,
    parameter int unsigned NACK_EVERY   = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_req_val,
    output logic                   mem_req_rdy,
    input  logic [ADDR_BITS-1:0]   mem_req_addr,
    input  logic                   mem_req_rw,
    input  logic                   mem_req_data_valid,
    output logic                   mem_req_data_ready,
    input  logic [DATA_BITS-1:0]   mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic [1:0]             mem_req_data_offset,
    output logic                   mem_resp_val,
    output logic                   mem_resp_nack,
    output logic [DATA_BITS-1:0]   mem_resp_data
);
    localparam int unsigned BEAT_W = clog2_min1(DATA_CYCLES);
    localparam int unsigned LAT_W  = clog2_min1(READ_LATENCY);
    localparam logic [ADDR_BITS-1:0] LINE_MASK = ADDR_BITS'(DATA_CYCLES - 1);
    localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(DATA_CYCLES - 1);
    localparam logic [LAT_W-1:0]     LAST_WAIT = LAT_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
    localparam bit                   NO_WAIT   = (READ_LATENCY == 1);

    if (READ_LATENCY < 1 || NACK_EVERY < 1 || (DATA_CYCLES & (DATA_CYCLES - 1)) != 0)
    begin : g_bad_params
        $error("mem_responder: illegal parameter combination");
    end

    state_e                 state, state_next;
    logic [ADDR_BITS-1:0]   addr_q;       // line base for reads, raw address for writes
    logic [LAT_W-1:0]       lat_cnt;
    logic [BEAT_W-1:0]      beat_cnt;
    logic                   accept_c;
    logic                   nack_now_c;   // the read being accepted now is due a nack
    logic                   nack_pend;    // the read in R_WAIT is due a nack
    logic [ADDR_BITS-1:0]   rd_base_c, wr_chunk_c, ram_addr_c;
    logic [BEAT_W-1:0]      rd_idx_c;
    logic                   wr_en_c;
    logic [DATA_BITS-1:0]   ram_rdata;

    assign accept_c = (state == ST_IDLE) && mem_req_val && mem_req_rdy;

`ifdef MEM_RESPONDER_NACK_EN
    localparam int unsigned NCNT_W = clog2_min1(NACK_EVERY);
    logic [NCNT_W-1:0] rd_cnt;

    assign nack_now_c = (rd_cnt == NCNT_W'(NACK_EVERY - 1));

    // Accepted reads modulo NACK_EVERY; nacked reads count too.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt    <= '0;
            nack_pend <= 1'b0;
        end else if (accept_c && !mem_req_rw) begin
            rd_cnt    <= nack_now_c ? '0 : rd_cnt + NCNT_W'(1);
            nack_pend <= nack_now_c;
        end
    end
`else
    assign nack_now_c = 1'b0;
    assign nack_pend  = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    if (mem_req_rw)   state_next = ST_W_DATA;
                    else if (NO_WAIT) state_next = nack_now_c ? ST_NACK : ST_R_BEAT;
                    else              state_next = ST_R_WAIT;
                end
            end
            ST_W_DATA: if (mem_req_data_valid) state_next = ST_IDLE;
            ST_R_WAIT: if (lat_cnt == LAST_WAIT) state_next = nack_pend ? ST_NACK : ST_R_BEAT;
            ST_R_BEAT: if (beat_cnt == LAST_BEAT) state_next = ST_IDLE;
            ST_NACK:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Single RAM port: write chunk in W_DATA, otherwise the beat about to be shown.
    // OR-ing the beat index into the aligned base keeps the read inside its line.
    assign rd_base_c  = (state == ST_IDLE) ? (mem_req_addr & ~LINE_MASK) : addr_q;
    assign rd_idx_c   = (state == ST_R_BEAT) ? beat_cnt + BEAT_W'(1) : '0;
    assign wr_chunk_c = (addr_q & ~ADDR_BITS'(3)) | ADDR_BITS'(mem_req_data_offset);
    assign wr_en_c    = (state == ST_W_DATA) && mem_req_data_valid && !reset;
    assign ram_addr_c = (state == ST_W_DATA) ? wr_chunk_c : (rd_base_c | ADDR_BITS'(rd_idx_c));

    mem_responder_array #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_array (
        .clk   (clk),
        .we    (wr_en_c),
        .addr  (ram_addr_c),
        .wmask (mem_req_data_mask),
        .wdata (mem_req_data_bits),
        .rdata (ram_rdata)
    );

    // Command address capture.
    always_ff @(posedge clk) begin
        if (accept_c) addr_q <= mem_req_rw ? mem_req_addr : (mem_req_addr & ~LINE_MASK);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= ST_IDLE;
            lat_cnt            <= '0;
            beat_cnt           <= '0;
            mem_req_rdy        <= 1'b0;
            mem_req_data_ready <= 1'b0;
            mem_resp_val       <= 1'b0;
            mem_resp_nack      <= 1'b0;
            mem_resp_data      <= '0;
        end else begin
            state              <= state_next;
            lat_cnt            <= (state == ST_R_WAIT && state_next == ST_R_WAIT) ? lat_cnt + LAT_W'(1) : '0;
            beat_cnt           <= (state == ST_R_BEAT) ? beat_cnt + BEAT_W'(1) : '0;
            mem_req_rdy        <= (state_next == ST_IDLE);
            mem_req_data_ready <= (state_next == ST_W_DATA);
            mem_resp_val       <= (state_next == ST_R_BEAT);
            mem_resp_nack      <= (state_next == ST_NACK);
            mem_resp_data      <= (state_next == ST_R_BEAT) ? ram_rdata : '0;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized scoreboard bench for mem_responder against a
// line/chunk memory model. Honors MEM_RESPONDER_NACK_EN when defined.
module tb_mem_responder;
    localparam int unsigned AB = 8;
    localparam int unsigned DB = 128;
    localparam int unsigned MB = DB / 8;
    localparam int unsigned DC = 4;
    localparam int unsigned RL = 4;
    localparam int unsigned NE = 3;
    localparam int unsigned DEPTH = 1 << AB;
`ifdef MEM_RESPONDER_NACK_EN
    localparam bit NACK_ON = 1'b1;
`else
    localparam bit NACK_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_req_val = 1'b0;
    logic          mem_req_rdy;
    logic [AB-1:0] mem_req_addr = '0;
    logic          mem_req_rw = 1'b0;
    logic          mem_req_data_valid = 1'b0;
    logic          mem_req_data_ready;
    logic [DB-1:0] mem_req_data_bits = '0;
    logic [MB-1:0] mem_req_data_mask = '0;
    logic [1:0]    mem_req_data_offset = '0;
    logic          mem_resp_val;
    logic          mem_resp_nack;
    logic [DB-1:0] mem_resp_data;

    mem_responder #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .DATA_CYCLES(DC), .READ_LATENCY(RL), .NACK_EVERY(NE)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
        .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
        .mem_req_data_offset(mem_req_data_offset),
        .mem_resp_val(mem_resp_val), .mem_resp_nack(mem_resp_nack), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [DB-1:0] act, input logic [DB-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model: plain chunk array plus read counter for nack period.
    typedef struct {
        bit            nack;
        logic [DB-1:0] data;
        int            when;
    } exp_t;

    exp_t          sbq[$];
    logic [DB-1:0] mem_m [DEPTH];
    int            rd_count = 0;
    int            last_issue = 0;
    exp_t          mon_e;

    function automatic logic [DB-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: every response cycle is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (mem_resp_val || mem_resp_nack) begin
            check("val_nack_exclusive", DB'(mem_resp_val & mem_resp_nack), '0);
            check("rdy_low_during_resp", DB'(mem_req_rdy), '0);
            if (sbq.size() == 0) begin
                fail_now("unexpected_response");
            end else begin
                mon_e = sbq.pop_front();
                check("resp_kind_nack", DB'(mem_resp_nack), DB'(mon_e.nack));
                check("resp_cycle", DB'(cyc), DB'(mon_e.when));
                if (!mon_e.nack) check("resp_data", mem_resp_data, mon_e.data);
            end
        end
    end

    // Wait (at negedge) until the responder can take a command; junk on the
    // write-data lines while busy must be ignored.
    task automatic wait_rdy();
        int n = 0;
        while (mem_req_rdy !== 1'b1 && n < 200) begin
            mem_req_data_valid = 1'($urandom);
            mem_req_data_bits  = rand_data();
            mem_req_data_mask  = MB'($urandom);
            @(negedge clk);
            n++;
        end
        mem_req_data_valid = 1'b0;
        if (n >= 200) fail_now("timeout_wait_rdy");
    endtask

    task automatic do_read(input logic [AB-1:0] a);
        logic [AB-1:0] base;
        wait_rdy();
        mem_req_val        = 1'b1;
        mem_req_rw         = 1'b0;
        mem_req_addr       = a;
        mem_req_data_valid = 1'($urandom);
        mem_req_data_bits  = rand_data();
        mem_req_data_mask  = '1;
        last_issue = cyc;
        rd_count++;
        base = a & ~AB'(DC - 1);
        if (NACK_ON && (rd_count % NE) == 0) begin
            sbq.push_back('{nack: 1'b1, data: '0, when: cyc + RL});
        end else begin
            for (int k = 0; k < DC; k++)
                sbq.push_back('{nack: 1'b0, data: mem_m[base + AB'(k)], when: cyc + RL + k});
        end
        @(negedge clk);
        mem_req_val        = 1'b0;
        mem_req_data_valid = 1'b0;
    endtask

    // delay = W_DATA cycles with data_valid low; early = offer junk data with the command.
    task automatic do_write(input logic [AB-1:0] a, input logic [1:0] off, input logic [MB-1:0] mask,
                            input logic [DB-1:0] data, input int delay, input bit early);
        logic [AB-1:0] chunk;
        wait_rdy();
        mem_req_val  = 1'b1;
        mem_req_rw   = 1'b1;
        mem_req_addr = a;
        if (early) begin
            mem_req_data_valid  = 1'b1;
            mem_req_data_bits   = ~data;
            mem_req_data_mask   = '1;
            mem_req_data_offset = off;
        end
        @(negedge clk);
        mem_req_val        = 1'b0;
        mem_req_data_valid = 1'b0;
        for (int i = 0; i <= delay; i++) begin
            check("wdata_ready_high", DB'(mem_req_data_ready), DB'(1));
            check("rdy_low_in_write", DB'(mem_req_rdy), '0);
            if (i == delay) begin
                mem_req_data_valid  = 1'b1;
                mem_req_data_bits   = data;
                mem_req_data_mask   = mask;
                mem_req_data_offset = off;
            end else begin
                mem_req_data_bits   = rand_data();
            end
            @(negedge clk);
        end
        mem_req_data_valid = 1'b0;
        check("rdy_after_write", DB'(mem_req_rdy), DB'(1));
        check("wdata_ready_low", DB'(mem_req_data_ready), '0);
        chunk = (a & ~AB'(3)) | AB'(off);
        for (int b = 0; b < MB; b++)
            if (mask[b]) mem_m[chunk][b*8 +: 8] = data[b*8 +: 8];
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_rdy", DB'(mem_req_rdy), '0);
            check("rst_wdata_ready", DB'(mem_req_data_ready), '0);
            check("rst_resp_val", DB'(mem_resp_val), '0);
            check("rst_resp_nack", DB'(mem_resp_nack), '0);
            check("rst_resp_data", mem_resp_data, '0);
        end
        reset = 1'b0;
        rd_count = 0;
        @(negedge clk);
        check("rdy_after_reset", DB'(mem_req_rdy), DB'(1));
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("scoreboard_drained", DB'(sbq.size()), '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DB-1:0] d;
        apply_reset(3);

        // Fill the whole array so every later read has a known answer.
        for (int c = 0; c < DEPTH; c++)
            do_write(AB'(c), 2'(c), '1, rand_data(), int'($urandom_range(0, 1)), 1'b0);

        // Masked write to chunk 5, then read its line.
        d = rand_data();
        d[31:0] = 32'hDDCCBBAA;
        do_write(8'h04, 2'd1, 16'h000F, d, 0, 1'b0);
        do_read(8'h04);

        // Unaligned read returns the aligned line in order.
        do_read(8'h07);

        // Slow write data with junk offered alongside the command.
        do_write(8'h22, 2'd3, 16'h0F0F, rand_data(), 5, 1'b1);
        do_read(8'h21);
        drain();

        // Six reads right after reset: nack period starts fresh.
        apply_reset(1);
        for (int r = 0; r < 6; r++) do_read(AB'($urandom));
        drain();

        // Random mix.
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(AB'($urandom), 2'($urandom), MB'($urandom), rand_data(),
                         int'($urandom_range(0, 3)), 1'($urandom));
            else
                do_read(AB'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        // Reset after the second beat of a read, then re-read the same line.
        if (NACK_ON && ((rd_count + 1) % NE) == 0) do_read(8'h10);
        drain();
        do_read(8'h31);
        while (cyc < last_issue + RL + 1) @(negedge clk);
        #1;
        sbq.delete();
        apply_reset(2);
        repeat (6) @(negedge clk);
        #1;
        check("no_resp_after_reset", DB'(sbq.size()), '0);
        do_read(8'h31);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
